// File: rtl/seg8_scan_driver_pkg.sv
// rtl/seg8_scan_driver_pkg.sv - shared constants and types for the 8-digit 7-segment scan driver
// Contents:
//   NUM_DIGITS  number of multiplexed digits
//   SEG_BLANK   active-low segment pattern with every segment off
//   ENB_NONE    active-low anode pattern with every digit off
//   HEX7_TABLE  active-low {g,f,e,d,c,b,a} patterns, indexed by nibble value
//   bank_t      one display bank (nibbles, decimal points, enable mask)
//   phase_e     blanking / driving phase inside a digit window
package seg8_scan_driver_pkg;

    localparam int NUM_DIGITS = 8;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [7:0] ENB_NONE  = 8'hFF;

    // Element n of this packed array is the pattern for nibble n (element 15 is written first).
    localparam logic [15:0][6:0] HEX7_TABLE = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    typedef struct packed {
        logic [31:0] digits;
        logic [7:0]  dp;
        logic [7:0]  en;
    } bank_t;

    typedef enum logic {
        PH_BLANK = 1'b0,
        PH_DRIVE = 1'b1
    } phase_e;

endpackage

// File: rtl/seg8_scan_driver_if.sv
// rtl/seg8_scan_driver_if.sv - data-load and display-pin bundle of the scan driver
// Signals:
//   digits_in    eight hex nibbles, digit k = digits_in[4k+3:4k]
//   dp_in        decimal point per digit, 1 = lit
//   digit_en_in  per-digit enable mask, 1 = shown
//   load         1-cycle strobe capturing the three fields above
//   inv_leds     active-low segments {g,f,e,d,c,b,a}
//   dp_n         active-low decimal point
//   enb_leds     active-low digit anodes, bit k = digit k
//   frame_tick   1-cycle pulse marking the frame boundary
//   upd_pending  shadow bank holds data not yet displayed
// master = data source / display side, slave = the scan driver.
interface seg8_scan_driver_if;

    logic [31:0] digits_in;
    logic [7:0]  dp_in;
    logic [7:0]  digit_en_in;
    logic        load;
    logic [6:0]  inv_leds;
    logic        dp_n;
    logic [7:0]  enb_leds;
    logic        frame_tick;
    logic        upd_pending;

    modport master (
        output digits_in, dp_in, digit_en_in, load,
        input  inv_leds, dp_n, enb_leds, frame_tick, upd_pending
    );

    modport slave (
        input  digits_in, dp_in, digit_en_in, load,
        output inv_leds, dp_n, enb_leds, frame_tick, upd_pending
    );

endinterface

// File: rtl/seg8_scan_driver_hex_to_7seg.sv
// rtl/seg8_scan_driver_hex_to_7seg.sv - combinational nibble to active-low 7-segment decoder
// Ports:
//   nibble_i  4-bit hex value
//   seg_n_o   active-low segments {g,f,e,d,c,b,a}
module hex_to_7seg
    import seg8_scan_driver_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_n_o
);

    always_comb begin
        seg_n_o = HEX7_TABLE[nibble_i];
    end

endmodule

// File: rtl/seg8_scan_driver.sv
// rtl/seg8_scan_driver.sv - tear-free multiplexed 8-digit common-anode 7-segment scan driver
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    slave side of seg8_scan_driver_if (load inputs, display pins, status)
// Parameters:
//   REFRESH_DIV   clk cycles per digit window (>= 2)
//   BLANK_CYCLES  cycles at the start of each window with all digits off (0 .. REFRESH_DIV-1)
module seg8_scan_driver
    import seg8_scan_driver_pkg::*;
#(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic               clk,
    input  logic               rst_n,
    seg8_scan_driver_if.slave  bus
);

    localparam int               CW       = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0]    DIV_LAST = CW'(REFRESH_DIV - 1);
    localparam int               IW       = $clog2(NUM_DIGITS);
    localparam logic [IW-1:0]    IDX_LAST = IW'(NUM_DIGITS - 1);

    if (REFRESH_DIV < 2 || BLANK_CYCLES < 0 || BLANK_CYCLES >= REFRESH_DIV) begin : g_bad_params
        $error("seg8_scan_driver: illegal REFRESH_DIV=%0d / BLANK_CYCLES=%0d", REFRESH_DIV, BLANK_CYCLES);
    end

    logic [CW-1:0] div_cnt_q, div_cnt_d;
    logic [IW-1:0] idx_q, idx_d;
    bank_t         shadow_q, shadow_d;
    bank_t         active_q, active_d;
    logic          pend_q, pend_d;
    logic          tick_q, tick_d;
    logic [6:0]    seg_q, seg_d;
    logic          dpn_q, dpn_d;
    logic [7:0]    enb_q, enb_d;

    logic          div_last;
    logic          frame_end;
    phase_e        phase;
    logic [3:0]    cur_nibble;
    logic [6:0]    cur_seg;

    hex_to_7seg u_hex (
        .nibble_i (cur_nibble),
        .seg_n_o  (cur_seg)
    );

    always_comb begin
        div_last   = (div_cnt_q == DIV_LAST);
        frame_end  = div_last && (idx_q == IDX_LAST);
        div_cnt_d  = div_last ? '0 : div_cnt_q + 1'b1;
        idx_d      = div_last ? idx_q + 1'b1 : idx_q;

        // Cast to int so a zero-length blanking period compares cleanly.
        phase      = (int'(div_cnt_q) < BLANK_CYCLES) ? PH_BLANK : PH_DRIVE;
        cur_nibble = active_q.digits[{idx_q, 2'b00} +: 4];

        // Shadow captures every load; the active bank only moves at a frame boundary,
        // and always takes the shadow as it was before any coincident load.
        shadow_d = shadow_q;
        active_d = active_q;
        pend_d   = pend_q;
        if (frame_end && pend_q) begin
            active_d = shadow_q;
            pend_d   = 1'b0;
        end
        if (bus.load) begin
            shadow_d = '{digits: bus.digits_in, dp: bus.dp_in, en: bus.digit_en_in};
            pend_d   = 1'b1;
        end

        tick_d = frame_end;
        seg_d  = SEG_BLANK;
        dpn_d  = 1'b1;
        enb_d  = ENB_NONE;
        if (phase == PH_DRIVE && active_q.en[idx_q]) begin
            enb_d = ~(8'b1 << idx_q);
            seg_d = cur_seg;
            dpn_d = ~active_q.dp[idx_q];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_q <= '0;
            idx_q     <= '0;
            shadow_q  <= '0;
            active_q  <= '0;
            pend_q    <= 1'b0;
            tick_q    <= 1'b0;
            seg_q     <= SEG_BLANK;
            dpn_q     <= 1'b1;
            enb_q     <= ENB_NONE;
        end else begin
            div_cnt_q <= div_cnt_d;
            idx_q     <= idx_d;
            shadow_q  <= shadow_d;
            active_q  <= active_d;
            pend_q    <= pend_d;
            tick_q    <= tick_d;
            seg_q     <= seg_d;
            dpn_q     <= dpn_d;
            enb_q     <= enb_d;
        end
    end

    assign bus.inv_leds    = seg_q;
    assign bus.dp_n        = dpn_q;
    assign bus.enb_leds    = enb_q;
    assign bus.frame_tick  = tick_q;
    assign bus.upd_pending = pend_q;

endmodule

// File: tb/tb_seg8_scan_driver.sv
// tb/tb_seg8_scan_driver.sv - self-checking bench for seg8_scan_driver
module tb_seg8_scan_driver;

    logic clk;
    logic rst_n;
    int   n_pass;
    int   n_total;

    seg8_scan_driver_if bus ();

    seg8_scan_driver #(
        .REFRESH_DIV  (8),
        .BLANK_CYCLES (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0]     digits;
        logic [7:0]      dp;
        logic [7:0]      en;
        logic [7:0][6:0] seg;
    } vec_t;

    vec_t tbl [5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Expected {enb_leds, inv_leds, dp_n} for frame position j (digit j/8, window cycle j%8).
    function automatic logic [15:0] exp_pos(input int vi, input int j);
        int         k;
        int         d;
        logic [7:0] one;
        k   = j / 8;
        d   = j % 8;
        one = 8'h01;
        if (d < 2 || !tbl[vi].en[k]) return {8'hFF, 7'h7F, 1'b1};
        return {~(one << k), tbl[vi].seg[k], ~tbl[vi].dp[k]};
    endfunction

    task automatic check_pos(input int vi, input int j);
        chk($sformatf("v%0d_pos%0d", vi, j), {16'h0, bus.enb_leds, bus.inv_leds, bus.dp_n},
            {16'h0, exp_pos(vi, j)});
    endtask

    task automatic apply_vec(input int vi);
        bus.digits_in   = tbl[vi].digits;
        bus.dp_in       = tbl[vi].dp;
        bus.digit_en_in = tbl[vi].en;
        bus.load        = 1'b1;
    endtask

    task automatic wait_tick();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (bus.frame_tick) seen = 1'b1;
        end
        n_total++;
        if (seen) n_pass++;
        else $display("FAIL wait_tick: got no frame_tick expected one within 200 cycles");
    endtask

    // Entered on a frame_tick cycle; checks the whole next frame against entry vi and
    // ends on the following frame_tick cycle. Loads happen at positions la / lb (-1 = none).
    task automatic run_frame(input int vi, input int la, input int lva,
                             input int lb, input int lvb, input logic pend_end);
        for (int j = 0; j < 64; j++) begin
            @(negedge clk);
            bus.load = 1'b0;
            check_pos(vi, j);
            if (j == 0)
                chk($sformatf("v%0d_tick_low", vi), {31'h0, bus.frame_tick}, 32'h0);
            if (j == 63) begin
                chk($sformatf("v%0d_tick_high", vi), {31'h0, bus.frame_tick}, 32'h1);
                chk($sformatf("v%0d_pend_end", vi), {31'h0, bus.upd_pending}, {31'h0, pend_end});
            end else if ((la >= 0 && j == la + 1) || (lb >= 0 && j == lb + 1)) begin
                chk($sformatf("v%0d_pend_after_load", vi), {31'h0, bus.upd_pending}, 32'h1);
            end
            if (j == la) apply_vec(lva);
            if (j == lb) apply_vec(lvb);
        end
    endtask

    initial begin
        int bad;
        n_pass  = 0;
        n_total = 0;

        tbl[0] = '{digits: 32'h0, dp: 8'h00, en: 8'h00, seg: {8{7'h7F}}};
        tbl[1] = '{digits: 32'h01234567, dp: 8'h01, en: 8'hFF,
                   seg: {7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78}};
        tbl[2] = '{digits: 32'h89ABCDEF, dp: 8'h80, en: 8'h0F,
                   seg: {7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E}};
        tbl[3] = '{digits: 32'h76543210, dp: 8'h00, en: 8'h5A,
                   seg: {7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40}};
        tbl[4] = '{digits: 32'hFFFFFFFF, dp: 8'hAA, en: 8'hFF, seg: {8{7'h0E}}};

        rst_n           = 1'b0;
        bus.digits_in   = '0;
        bus.dp_in       = '0;
        bus.digit_en_in = '0;
        bus.load        = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", {7'h0, bus.enb_leds, bus.inv_leds, bus.dp_n, bus.frame_tick, bus.upd_pending, 7'h0},
            {7'h0, 8'hFF, 7'h7F, 1'b1, 1'b0, 1'b0, 7'h0});
        rst_n = 1'b1;

        wait_tick();

        // Each frame shows the previous entry while the next one is loaded early in it.
        for (int vi = 1; vi < 5; vi++)
            run_frame(vi - 1, 0, vi, -1, 0, 1'b0);

        // Load at the start of digit 3's window: the running frame must not change.
        run_frame(4, 23, 1, -1, 0, 1'b0);
        // Pending load mid-frame, then another load exactly on the boundary cycle.
        run_frame(1, 30, 3, 62, 2, 1'b1);
        // The pre-boundary shadow is shown; the boundary load follows one frame later.
        run_frame(3, -1, 0, -1, 0, 1'b0);
        // Two loads in one frame: the later one wins.
        run_frame(2, 10, 0, 20, 4, 1'b0);
        run_frame(4, -1, 0, -1, 0, 1'b0);

        // Asynchronous reset while digit 2 is being driven.
        for (int j = 0; j < 20; j++) begin
            @(negedge clk);
            check_pos(4, j);
        end
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset", {8'h0, bus.enb_leds, bus.inv_leds, bus.dp_n, bus.frame_tick, bus.upd_pending},
            {8'h0, 8'hFF, 7'h7F, 1'b1, 1'b0, 1'b0});
        @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        for (int j = 0; j < 80; j++) begin
            @(negedge clk);
            if (bus.enb_leds !== 8'hFF || bus.inv_leds !== 7'h7F || bus.dp_n !== 1'b1) bad++;
        end
        chk("blank_after_reset_bad_cycles", bad, 0);
        chk("pend_after_reset", {31'h0, bus.upd_pending}, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
